// File: rtl/axis_out_pkg.sv
// Shared sizing for the FIR output stream buffer.
// Defaults and the occupancy-width helper live here.
package axis_out_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage: register array with one write and one async read port.
// Contents are never reset; the pointers in the parent decide validity.
module axis_fifo_mem
    import axis_out_pkg::*;
#(
    parameter int unsigned pWIDTH = DATA_W + 1,
    parameter int unsigned pDEPTH = DEPTH
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [$clog2(pDEPTH)-1:0] waddr_i,
    input  logic [pWIDTH-1:0]         wdata_i,
    input  logic [$clog2(pDEPTH)-1:0] raddr_i,
    output logic [pWIDTH-1:0]         rdata_o
);

    logic [pWIDTH-1:0] mem_q [pDEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_out_fifo.sv
// Show-ahead AXI-Stream FIFO behind the FIR core output, with
// frame-length checking and a frame-done pulse on the output side.
module axis_out_fifo
    import axis_out_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = DATA_W,
    parameter int unsigned pDEPTH      = DEPTH
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    input  logic [pDATA_WIDTH-1:0]        s_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [pDATA_WIDTH-1:0]        m_tdata,
    input  logic [31:0]                   cfg_length,
    output logic [lvl_w(pDEPTH)-1:0]      level,
    output logic                          len_err,
    output logic                          frame_done
);

    localparam int unsigned AW = $clog2(pDEPTH);
    localparam int unsigned LW = lvl_w(pDEPTH);
    localparam int unsigned EW = pDATA_WIDTH + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          rdy_q;

    logic          push, pop;
    logic [EW-1:0] head;
    logic [31:0]   cnt_inc;
    logic          chk_en;

    axis_fifo_mem #(
        .pWIDTH (EW),
        .pDEPTH (pDEPTH)
    ) u_mem (
        .clk_i   (axis_clk),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i ({s_tlast, s_tdata}),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    // rdy_q holds s_tready low until the first edge after reset release.
    assign s_tready   = rdy_q && (level_q < LW'(pDEPTH));
    assign m_tvalid   = (level_q != '0);
    assign m_tdata    = m_tvalid ? head[pDATA_WIDTH-1:0] : '0;
    assign m_tlast    = m_tvalid ? head[EW-1] : 1'b0;
    assign level      = level_q;
    assign len_err    = err_q;
    assign frame_done = done_q;

    assign push    = s_tvalid && s_tready;
    assign pop     = m_tvalid && m_tready;
    assign cnt_inc = beat_cnt_q + 32'd1;
    assign chk_en  = (cfg_length != 32'd0);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        done_d     = pop && head[EW-1];

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (push) begin
            if (s_tlast) begin
                beat_cnt_d = '0;
                if (chk_en && (cnt_inc != cfg_length)) begin
                    err_d = 1'b1;
                end
            end else if (chk_en && (cnt_inc == cfg_length)) begin
                beat_cnt_d = '0;
                err_d      = 1'b1;
            end else begin
                beat_cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            rdy_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_out_fifo.sv
// Scoreboard bench for axis_out_fifo: expected beats are queued on
// acceptance and compared against the show-ahead head on every cycle.
module tb_axis_out_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic [31:0] cfg_length = '0;
    logic [4:0]  level;
    logic        len_err;
    logic        frame_done;

    axis_out_fifo #(
        .pDATA_WIDTH (32),
        .pDEPTH      (16)
    ) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .s_tdata    (s_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .cfg_length (cfg_length),
        .level      (level),
        .len_err    (len_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [32:0] sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        rdy_ok = 1'b0;
    logic        fd_exp = 1'b0;
    logic        err_exp = 1'b0;
    logic [31:0] cnt_m = '0;
    int          fd_seen = 0;
    int          out_cnt = 0;
    logic        last_acc = 1'b0;

    // One clock of stimulus; checks DUT state against the model first.
    task automatic step(input logic sv, input logic [31:0] sd,
                        input logic sl, input logic mr);
        logic        acc;
        logic        pp;
        logic [32:0] head;
        @(negedge clk);
        s_tvalid = sv;
        s_tdata  = sd;
        s_tlast  = sl;
        m_tready = mr;
        #1;
        n_checks++;
        if (frame_done !== fd_exp) begin
            n_fail++;
            $display("FAIL frame_done: got %b want %b", frame_done, fd_exp);
        end
        if (frame_done === 1'b1) fd_seen++;
        n_checks++;
        if (level !== 5'(sb.size())) begin
            n_fail++;
            $display("FAIL level: got %0d want %0d", level, sb.size());
        end
        n_checks++;
        if (m_tvalid !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL m_tvalid: got %b want %b", m_tvalid, sb.size() != 0);
        end
        n_checks++;
        if (s_tready !== (rdy_ok && sb.size() < 16)) begin
            n_fail++;
            $display("FAIL s_tready: got %b want %b", s_tready,
                     rdy_ok && sb.size() < 16);
        end
        n_checks++;
        if (len_err !== err_exp) begin
            n_fail++;
            $display("FAIL len_err: got %b want %b", len_err, err_exp);
        end
        head = '0;
        if (sb.size() != 0) begin
            head = sb[0];
            n_checks++;
            if ({m_tlast, m_tdata} !== head) begin
                n_fail++;
                $display("FAIL head: got %b/%h want %b/%h",
                         m_tlast, m_tdata, head[32], head[31:0]);
            end
        end
        acc      = sv && (s_tready === 1'b1);
        pp       = (m_tvalid === 1'b1) && mr;
        last_acc = acc;
        fd_exp   = pp && head[32];
        if (pp) begin
            out_cnt++;
            if (sb.size() != 0) void'(sb.pop_front());
        end
        if (acc) begin
            sb.push_back({sl, sd});
            if (sl) begin
                if (cfg_length != 0 && cnt_m + 1 != cfg_length) err_exp = 1'b1;
                cnt_m = '0;
            end else if (cfg_length != 0 && cnt_m + 1 == cfg_length) begin
                err_exp = 1'b1;
                cnt_m   = '0;
            end else begin
                cnt_m = cnt_m + 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            step(1'b0, '0, 1'b0, 1'b1);
            guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: left %0d want 0", sb.size());
        end
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({s_tready, m_tvalid, m_tlast, len_err, frame_done} !== 5'b0 ||
            m_tdata !== '0 || level !== '0) begin
            n_fail++;
            $display("FAIL %s: rdy=%b vld=%b last=%b err=%b fd=%b data=%h lvl=%0d want all 0",
                     tag, s_tready, m_tvalid, m_tlast, len_err, frame_done,
                     m_tdata, level);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        rdy_ok  = 1'b0;
        fd_exp  = 1'b0;
        err_exp = 1'b0;
        cnt_m   = '0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_before_edge: got %b want 0", s_tready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (s_tready !== 1'b1 || level !== '0) begin
            n_fail++;
            $display("FAIL rdy_after_edge: got %b lvl %0d want 1 lvl 0",
                     s_tready, level);
        end
        rdy_ok = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        release_reset();
    endtask

    task automatic test_latency();
        cfg_length = 0;
        step(1'b1, 32'h0000_0007, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'd7 || level !== 5'd1) begin
            n_fail++;
            $display("FAIL latency: vld=%b data=%h lvl=%0d want 1 7 1",
                     m_tvalid, m_tdata, level);
        end
        drain();
    endtask

    task automatic test_long_frame();
        int i = 0;
        int guard = 0;
        int fd0 = fd_seen;
        int o0 = out_cnt;
        cfg_length = 600;
        while (i < 600 && guard < 2000) begin
            step(1'b1, $urandom, (i == 599), 1'b1);
            if (last_acc) i++;
            guard++;
        end
        drain();
        n_checks++;
        if (out_cnt - o0 != 600 || fd_seen - fd0 != 1 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL long_frame: out=%0d fd=%0d err=%b want 600 1 0",
                     out_cnt - o0, fd_seen - fd0, len_err);
        end
    endtask

    task automatic test_backpressure();
        int i = 0;
        int guard = 0;
        cfg_length = 0;
        repeat (20) begin
            step(1'b1, 32'h1000 + i, (i == 19), 1'b0);
            if (last_acc) i++;
        end
        #1;
        n_checks++;
        if (i != 16 || level !== 5'd16 || s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL full: acc=%0d lvl=%0d rdy=%b want 16 16 0",
                     i, level, s_tready);
        end
        while (i < 20 && guard < 100) begin
            step(1'b1, 32'h1000 + i, (i == 19), 1'b1);
            if (last_acc) i++;
            guard++;
        end
        drain();
    endtask

    task automatic test_steady();
        int i = 0;
        cfg_length = 0;
        while (i < 8) begin
            step(1'b1, $urandom, 1'b0, 1'b0);
            if (last_acc) i++;
        end
        repeat (50) begin
            step(1'b1, $urandom, 1'b0, 1'b1);
            #1;
            n_checks++;
            if (level !== 5'd8) begin
                n_fail++;
                $display("FAIL steady_level: got %0d want 8", level);
            end
        end
        drain();
        n_checks++;
        if (len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL no_check_len0: got %b want 0", len_err);
        end
    endtask

    task automatic test_len_err();
        cfg_length = 11;
        for (int k = 0; k < 10; k++) step(1'b1, 32'hA000 + k, (k == 9), 1'b1);
        #1;
        n_checks++;
        if (len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL short_frame_err: got %b want 1", len_err);
        end
        for (int k = 0; k < 11; k++) step(1'b1, 32'hB000 + k, (k == 10), 1'b1);
        drain();
        n_checks++;
        if (len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", len_err);
        end
    endtask

    task automatic test_reset_mid();
        int i = 0;
        cfg_length = 0;
        while (i < 5) begin
            step(1'b1, 32'hC000 + i, 1'b0, 1'b0);
            if (last_acc) i++;
        end
        #1;
        n_checks++;
        if (level !== 5'd5) begin
            n_fail++;
            $display("FAIL pre_reset_level: got %0d want 5", level);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
        repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_early_err();
        cfg_length = 5;
        for (int k = 0; k < 4; k++) step(1'b1, 32'hD000 + k, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_err_pre: got %b want 0", len_err);
        end
        step(1'b1, 32'hD004, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL early_err_set: got %b want 1", len_err);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 32'hE000 + k, (k == 2), 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_long_frame();
        test_backpressure();
        test_steady();
        test_len_err();
        test_reset_mid();
        test_early_err();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
